tt_capture_8_5: RTL and testbench

TT_CAPTURE_8_5 -- requirements
Module: tt_capture_8_5

---
 rtl/tt_capture_8_5_if.sv | 36 +++
 rtl/tt_capture_8_5.sv | 121 ++++++++++++
 tb/tb_tt_capture_8_5.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_capture_8_5_if.sv
// Bus bundle for tt_capture_8_5: sweep control, stimulus/response pair and table readback.
// Defining TT_CAPTURE_CHECK_EN adds the reference response and mismatch reporting signals.
interface tt_capture_8_5_if;
    logic       i_start;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_x;
    logic [4:0] i_y;
    logic [7:0] i_rd_addr;
    logic [4:0] o_rd_data;
`ifdef TT_CAPTURE_CHECK_EN
    logic [4:0] i_ref_y;
    logic       o_err;
    logic [8:0] o_err_cnt;

    modport master (
        input  i_start, i_y, i_rd_addr, i_ref_y,
        output o_busy, o_done, o_x, o_rd_data, o_err, o_err_cnt
    );

    modport slave (
        output i_start, i_y, i_rd_addr, i_ref_y,
        input  o_busy, o_done, o_x, o_rd_data, o_err, o_err_cnt
    );
`else
    modport master (
        input  i_start, i_y, i_rd_addr,
        output o_busy, o_done, o_x, o_rd_data
    );

    modport slave (
        output i_start, i_y, i_rd_addr,
        input  o_busy, o_done, o_x, o_rd_data
    );
`endif
endinterface

// File: rtl/tt_capture_8_5.sv
// Truth-table capture engine: sweeps an 8-bit stimulus over a combinational block and records its 5-bit response.
// Optional TT_CAPTURE_CHECK_EN adds a per-vector compare against a reference response.
module tt_capture_8_5 #(
    parameter int SETTLE_CYCLES = 2
) (
    input logic              clk,
    input logic              i_rst_n,
    tt_capture_8_5_if.master bus
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] x;
    logic [7:0] x_nxt;
    logic [3:0] settle_cnt;
    logic [3:0] settle_cnt_nxt;
    logic       wr_en;
    logic       busy;
    logic       done;
    logic [4:0] cap_mem [256];
    logic [4:0] rd_data;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            x          <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        x_nxt          = x;
        settle_cnt_nxt = settle_cnt;
        wr_en          = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    x_nxt          = '0;
                    settle_cnt_nxt = '0;
                    state_nxt      = SETTLE;
                end
            end
            SETTLE: begin
                busy           = 1'b1;
                settle_cnt_nxt = settle_cnt + 4'd1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                // The last vector leaves o_x parked at 255 instead of wrapping.
                if (x == 8'd255) begin
                    state_nxt = DONE;
                end else begin
                    x_nxt          = x + 8'd1;
                    settle_cnt_nxt = '0;
                    state_nxt      = SETTLE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The table itself is never cleared; a capture coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && i_rst_n) begin
            cap_mem[x] <= bus.i_y;
        end
    end

    // Sampling the array before this edge's write lands gives read-before-write.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= cap_mem[bus.i_rd_addr];
        end
    end

    assign bus.o_x       = x;
    assign bus.o_busy    = busy;
    assign bus.o_done    = done;
    assign bus.o_rd_data = rd_data;

`ifdef TT_CAPTURE_CHECK_EN
    logic       err;
    logic [8:0] err_cnt;

    // Results persist after a sweep and are cleared only by reset or the next accepted start.
    always_ff @(posedge clk) begin
        if (!i_rst_n || (state == IDLE && bus.i_start)) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (state == CAPTURE && bus.i_y != bus.i_ref_y) begin
            err <= 1'b1;
            if (err_cnt != 9'd256) begin
                err_cnt <= err_cnt + 9'd1;
            end
        end
    end

    assign bus.o_err     = err;
    assign bus.o_err_cnt = err_cnt;
`endif
endmodule

// File: tb/tb_tt_capture_8_5.sv
// Scoreboard bench for tt_capture_8_5: one instance with SETTLE_CYCLES=2 and one with SETTLE_CYCLES=1.
// Expected sweep timing and table contents come from closed-form arithmetic over the sweep start cycle.
module tb_tt_capture_8_5;
    localparam int S_A = 2;
    localparam int S_B = 1;

    typedef struct packed {
        logic       active;
        int         n0;
        int         s;
        logic [7:0] hold_x;
    } sweep_t;

    typedef struct packed {
        int         due;
        logic [7:0] addr;
        logic [4:0] val;
    } rd_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    logic [4:0] key_a = '0;
    logic [7:0] key_b = '0;
    logic [4:0] y_b_q = '0;

    sweep_t     m [2];
    int         done_q [2][$];
    rd_t        rd_q [2][$];
    logic [4:0] tbl [2][256];

    tt_capture_8_5_if bus_a ();
    tt_capture_8_5_if bus_b ();

    tt_capture_8_5 #(.SETTLE_CYCLES(S_A)) u_dut_a (
        .clk     (clk),
        .i_rst_n (rst_a_n),
        .bus     (bus_a)
    );

    tt_capture_8_5 #(.SETTLE_CYCLES(S_B)) u_dut_b (
        .clk     (clk),
        .i_rst_n (rst_b_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] f_b(input logic [7:0] x, input logic [7:0] k);
        int t;
        t = int'(x) * 13 + int'(k);
        return 5'(t);
    endfunction

    // Block A is purely combinational; block B settles one clock after its input moves.
    assign bus_a.i_y = bus_a.o_x[4:0] ^ key_a;
    always @(posedge clk) y_b_q <= f_b(bus_b.o_x, key_b);
    assign bus_b.i_y = y_b_q;

`ifdef TT_CAPTURE_CHECK_EN
    logic ref_bad_a = 1'b0;
    assign bus_a.i_ref_y = bus_a.i_y ^ {4'b0, ref_bad_a && (bus_a.o_x == 8'd3 || bus_a.o_x == 8'd200)};
    assign bus_b.i_ref_y = bus_b.i_y;
`endif

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] get_x(input int k);
        return (k == 0) ? bus_a.o_x : bus_b.o_x;
    endfunction

    function automatic logic get_busy(input int k);
        return (k == 0) ? bus_a.o_busy : bus_b.o_busy;
    endfunction

    function automatic logic get_done(input int k);
        return (k == 0) ? bus_a.o_done : bus_b.o_done;
    endfunction

    function automatic logic [4:0] get_rd(input int k);
        return (k == 0) ? bus_a.o_rd_data : bus_b.o_rd_data;
    endfunction

    // Vector v occupies cycles n0+1+v*(s+1) .. n0+(v+1)*(s+1) after the start cycle n0.
    task automatic exp_state(input sweep_t ms, input int c, output logic [7:0] ex, output logic eb);
        int d;
        ex = ms.hold_x;
        eb = 1'b0;
        if (ms.active) begin
            d = c - ms.n0;
            if (d >= 1 && d <= 256 * (ms.s + 1)) begin
                eb = 1'b1;
                ex = 8'((d - 1) / (ms.s + 1));
            end else if (d > 256 * (ms.s + 1)) begin
                ex = 8'd255;
            end
        end
    endtask

    task automatic monitor(input int k);
        logic [7:0] ex;
        logic       eb;
        rd_t        r;
        int         due;
        exp_state(m[k], cyc, ex, eb);
        check_output($sformatf("dut%0d o_x", k), int'(get_x(k)), int'(ex));
        check_output($sformatf("dut%0d o_busy", k), int'(get_busy(k)), int'(eb));
        if (get_done(k)) begin
            if (done_q[k].size() == 0) begin
                check_output($sformatf("dut%0d unexpected o_done", k), int'(get_done(k)), 0);
            end else begin
                due = done_q[k].pop_front();
                check_output($sformatf("dut%0d o_done cycle", k), cyc, due);
            end
        end else if (done_q[k].size() > 0 && cyc >= done_q[k][0]) begin
            check_output($sformatf("dut%0d o_done missing", k), int'(get_done(k)), 1);
            void'(done_q[k].pop_front());
        end
        while (rd_q[k].size() > 0 && rd_q[k][0].due <= cyc) begin
            r = rd_q[k].pop_front();
            check_output($sformatf("dut%0d rd[%0h]", k, r.addr), int'(get_rd(k)), int'(r.val));
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            monitor(0);
            monitor(1);
        end
    end

    task automatic set_start(input int k, input logic v);
        if (k == 0) bus_a.i_start = v;
        else        bus_b.i_start = v;
    endtask

    task automatic start_sweep(input int k);
        set_start(k, 1'b1);
        m[k].active = 1'b1;
        m[k].n0     = cyc;
        done_q[k].push_back(cyc + 256 * (m[k].s + 1) + 1);
        @(negedge clk);
        set_start(k, 1'b0);
    endtask

    task automatic apply_stimulus(input int k, input logic [7:0] a, input logic [4:0] ev);
        rd_t r;
        if (k == 0) bus_a.i_rd_addr = a;
        else        bus_b.i_rd_addr = a;
        r.due  = cyc + 1;
        r.addr = a;
        r.val  = ev;
        rd_q[k].push_back(r);
        @(negedge clk);
    endtask

    task automatic wait_x(input int k, input logic [7:0] v);
        for (int i = 0; i < 3000; i++) begin
            if (get_x(k) == v) return;
            @(negedge clk);
        end
        check_output($sformatf("dut%0d timeout waiting o_x", k), int'(get_x(k)), int'(v));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Entry a of the running sweep on A is visible to a read sampled after edge n+1 only if written at or before edge n.
    function automatic logic [4:0] exp_rd_a(input int a, input int n);
        int we;
        we = m[0].n0 + (a + 1) * (m[0].s + 1) + 1;
        return (we <= n) ? (5'(a) ^ key_a) : tbl[0][a];
    endfunction

    initial begin
        int         v;
        int         a;
        int         abort_cyc;
        logic [7:0] ra;

        rst_a_n         = 1'b0;
        rst_b_n         = 1'b0;
        bus_a.i_start   = 1'b0;
        bus_b.i_start   = 1'b0;
        bus_a.i_rd_addr = '0;
        bus_b.i_rd_addr = '0;
        m[0] = '{active: 1'b0, n0: 0, s: S_A, hold_x: 8'd0};
        m[1] = '{active: 1'b0, n0: 0, s: S_B, hold_x: 8'd0};
`ifdef TT_CAPTURE_CHECK_EN
        ref_bad_a = 1'b1;
`endif
        repeat (3) @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("dut%0d reset o_x", k), int'(get_x(k)), 0);
            check_output($sformatf("dut%0d reset o_busy", k), int'(get_busy(k)), 0);
            check_output($sformatf("dut%0d reset o_done", k), int'(get_done(k)), 0);
            check_output($sformatf("dut%0d reset o_rd_data", k), int'(get_rd(k)), 0);
        end
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        $display("[TB] sweep A with y = x[4:0], second start at vector 40");
        start_sweep(0);
        wait_x(0, 8'd40);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        wait_until(m[0].n0 + 256 * (S_A + 1) + 3);
        for (int i = 0; i < 256; i++) tbl[0][i] = 5'(i);

        apply_stimulus(0, 8'hA7, 5'b00111);
        apply_stimulus(0, 8'hFF, 5'b11111);
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 255));
            apply_stimulus(0, ra, tbl[0][ra]);
        end
`ifdef TT_CAPTURE_CHECK_EN
        check_output("dut0 err_cnt after sweep", int'(bus_a.o_err_cnt), 2);
        check_output("dut0 err after sweep", int'(bus_a.o_err), 1);
        ref_bad_a = 1'b0;
`endif

        $display("[TB] sweep A with new key, reads during sweep, reset at vector 100");
        key_a = 5'($urandom_range(1, 31));
        start_sweep(0);
`ifdef TT_CAPTURE_CHECK_EN
        check_output("dut0 err_cnt cleared by start", int'(bus_a.o_err_cnt), 0);
        check_output("dut0 err cleared by start", int'(bus_a.o_err), 0);
`endif
        for (int i = 0; i < 30; i++) begin
            v = (cyc - m[0].n0 - 1) / (S_A + 1);
            a = (i % 2 == 0) ? v : int'($urandom_range(0, v + 2));
            apply_stimulus(0, 8'(a), exp_rd_a(a, cyc));
        end
        wait_x(0, 8'd100);
        abort_cyc = cyc;
        rst_a_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (m[0].n0 + (i + 1) * (S_A + 1) + 1 <= abort_cyc) tbl[0][i] = 5'(i) ^ key_a;
        end
        m[0].active = 1'b0;
        m[0].hold_x = 8'd0;
        done_q[0].delete();
        @(negedge clk);
        check_output("dut0 abort o_x", int'(bus_a.o_x), 0);
        check_output("dut0 abort o_busy", int'(bus_a.o_busy), 0);
        check_output("dut0 abort o_done", int'(bus_a.o_done), 0);
        check_output("dut0 abort o_rd_data", int'(bus_a.o_rd_data), 0);
`ifdef TT_CAPTURE_CHECK_EN
        check_output("dut0 abort err_cnt", int'(bus_a.o_err_cnt), 0);
`endif
        rst_a_n = 1'b1;
        @(negedge clk);
        apply_stimulus(0, 8'd50, 5'(50) ^ key_a);
        apply_stimulus(0, 8'd99, 5'(99) ^ key_a);
        apply_stimulus(0, 8'd100, 5'(100));
        apply_stimulus(0, 8'd150, 5'(150));
        repeat (10) @(negedge clk);

        $display("[TB] sweep B with SETTLE_CYCLES=1 and a lagging response");
        key_b = 8'($urandom_range(0, 255));
        @(negedge clk);
        start_sweep(1);
        wait_until(m[1].n0 + 256 * (S_B + 1) + 3);
        for (int i = 0; i < 256; i++) tbl[1][i] = f_b(8'(i), key_b);
        apply_stimulus(1, 8'd0, tbl[1][0]);
        apply_stimulus(1, 8'd255, tbl[1][255]);
        for (int i = 0; i < 14; i++) begin
            ra = 8'($urandom_range(0, 255));
            apply_stimulus(1, ra, tbl[1][ra]);
        end
`ifdef TT_CAPTURE_CHECK_EN
        check_output("dut1 err_cnt", int'(bus_b.o_err_cnt), 0);
`endif
        repeat (3) @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("dut%0d pending o_done", k), done_q[k].size(), 0);
            check_output($sformatf("dut%0d pending reads", k), rd_q[k].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
